// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared mode constants and config FSM encoding for the DDS generators
package dds_pkg;

  localparam logic [1:0] MODE_TRI  = 2'd0;
  localparam logic [1:0] MODE_SAW  = 2'd1;
  localparam logic [1:0] MODE_SQR  = 2'd2;
  localparam logic [1:0] MODE_MUTE = 2'd3;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/dds_wave_map.sv
// rtl/dds_wave_map.sv - combinational phase-to-sample mapper (triangle/sawtooth/square/mute)
//   phase  : accumulated phase, ACC_W bits
//   mode   : waveform select (dds_pkg MODE_*)
//   sample : signed two's-complement sample, OUT_W bits
module dds_wave_map
  import dds_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int OUT_W = 16
) (
  input  logic [ACC_W-1:0] phase,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] sample
);

  localparam logic [OUT_W-1:0] POS_FS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_FS = {1'b1, {(OUT_W-1){1'b0}}};

  logic             half_sel;
  logic [OUT_W-1:0] ramp;
  logic [OUT_W-1:0] saw_raw;

  // ramp spans one half period, so the triangle rises over the lower half of
  // the phase circle and falls over the upper half.
  assign half_sel = phase[ACC_W-1];
  assign ramp     = phase[ACC_W-2 -: OUT_W];
  assign saw_raw  = phase[ACC_W-1 -: OUT_W];

  always_comb begin
    sample = '0;
    case (mode)
      MODE_TRI: sample = half_sel ? (POS_FS - ramp) : (ramp - NEG_FS);
      // offset-binary to two's complement: flip the top bit
      MODE_SAW: sample = {~saw_raw[OUT_W-1], saw_raw[OUT_W-2:0]};
      MODE_SQR: sample = half_sel ? NEG_FS : POS_FS;
      default:  sample = '0;
    endcase
  end

endmodule

// File: rtl/dds_multiwave_gen.sv
// rtl/dds_multiwave_gen.sv - multi-waveform DDS with wrap-synchronised reconfiguration
//   clk, resetn            : clock, asynchronous active-low reset
//   enable                 : accumulator advances when high, holds when low
//   cfg_valid / cfg_ready  : config handshake
//   cfg_fcw, cfg_phase     : new frequency word and phase offset
//   cfg_mode               : new waveform mode
//   wave_out               : registered signed sample
//   wrap_pulse             : one-cycle pulse on accumulator carry-out
module dds_multiwave_gen
  import dds_pkg::*;
#(
  parameter int          ACC_W    = 24,
  parameter int          OUT_W    = 16,
  parameter int unsigned FCW_RST  = 16600,
  parameter int unsigned MODE_RST = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ACC_W-1:0] cfg_fcw,
  input  logic [ACC_W-1:0] cfg_phase,
  input  logic [1:0]       cfg_mode,
  output logic [OUT_W-1:0] wave_out,
  output logic             wrap_pulse
);

  localparam logic [ACC_W-1:0] FCW_RST_V  = ACC_W'(FCW_RST);
  localparam logic [1:0]       MODE_RST_V = 2'(MODE_RST);

  cfg_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] fcw_q, fcw_d;
  logic [ACC_W-1:0] phase_q, phase_d;
  logic [1:0]       mode_q, mode_d;
  logic [ACC_W-1:0] sh_fcw_q, sh_fcw_d;
  logic [ACC_W-1:0] sh_phase_q, sh_phase_d;
  logic [1:0]       sh_mode_q, sh_mode_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             wrap_q, wrap_d;
  logic [OUT_W-1:0] wave_q, wave_d;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] p;

  assign sum   = {1'b0, acc_q} + {1'b0, fcw_q};
  assign carry = sum[ACC_W];
  assign p     = acc_q + phase_q;

  dds_wave_map #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_wave_map (
    .phase  (p),
    .mode   (mode_q),
    .sample (wave_d)
  );

  always_comb begin
    acc_d       = enable ? sum[ACC_W-1:0] : acc_q;
    wrap_d      = carry & enable;
    state_d     = state_q;
    fcw_d       = fcw_q;
    phase_d     = phase_q;
    mode_d      = mode_q;
    sh_fcw_d    = sh_fcw_q;
    sh_phase_d  = sh_phase_q;
    sh_mode_d   = sh_mode_q;
    cfg_ready_d = cfg_ready_q;

    case (state_q)
      ST_RUN: begin
        // A capture coinciding with a wrap is only captured; it waits for
        // the following wrap so the current period completes unchanged.
        if (cfg_valid && cfg_ready_q) begin
          sh_fcw_d    = cfg_fcw;
          sh_phase_d  = cfg_phase;
          sh_mode_d   = cfg_mode;
          cfg_ready_d = 1'b0;
          state_d     = ST_PEND;
        end
      end
      ST_PEND: begin
        // Apply on the wrap edge while running; when stopped there is no
        // waveform to glitch, so apply immediately.
        if (!enable || carry) begin
          fcw_d       = sh_fcw_q;
          phase_d     = sh_phase_q;
          mode_d      = sh_mode_q;
          cfg_ready_d = 1'b1;
          state_d     = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_RUN;
      acc_q       <= '0;
      fcw_q       <= FCW_RST_V;
      phase_q     <= '0;
      mode_q      <= MODE_RST_V;
      sh_fcw_q    <= '0;
      sh_phase_q  <= '0;
      sh_mode_q   <= '0;
      cfg_ready_q <= 1'b1;
      wrap_q      <= 1'b0;
      wave_q      <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      fcw_q       <= fcw_d;
      phase_q     <= phase_d;
      mode_q      <= mode_d;
      sh_fcw_q    <= sh_fcw_d;
      sh_phase_q  <= sh_phase_d;
      sh_mode_q   <= sh_mode_d;
      cfg_ready_q <= cfg_ready_d;
      wrap_q      <= wrap_d;
      wave_q      <= wave_d;
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign wrap_pulse = wrap_q;
  assign wave_out   = wave_q;

endmodule

// File: tb/tb_dds_multiwave_gen.sv
// tb/tb_dds_multiwave_gen.sv - self-checking bench for dds_multiwave_gen
module tb_dds_multiwave_gen;

  localparam logic [23:0] F22 = 24'h400000;
  localparam logic [23:0] F21 = 24'h200000;
  // 1011 steps of 16600 wrap with residue 5384; this phase cancels it so P starts at 0
  localparam logic [23:0] PA  = 24'hFFEAF8;
  localparam logic [23:0] PB  = 24'h3FEAF8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [23:0] cfg_fcw;
  logic [23:0] cfg_phase;
  logic [1:0]  cfg_mode;
  logic [15:0] wave_out;
  logic        wrap_pulse;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic        vld;
    logic [23:0] fcw;
    logic [23:0] ph;
    logic [1:0]  mode;
    logic [15:0] exp_wave;
    logic        exp_wrap;
    logic        exp_rdy;
  } vec_t;

  vec_t vecs[32];

  dds_multiwave_gen #(
    .ACC_W    (24),
    .OUT_W    (16),
    .FCW_RST  (16600),
    .MODE_RST (0)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_fcw    (cfg_fcw),
    .cfg_phase  (cfg_phase),
    .cfg_mode   (cfg_mode),
    .wave_out   (wave_out),
    .wrap_pulse (wrap_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout sim time exceeded");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic en, input logic vld, input logic [23:0] fcw,
                              input logic [23:0] ph, input logic [1:0] mode,
                              input logic [15:0] w, input logic wr, input logic rd);
    vec_t v;
    v.en = en; v.vld = vld; v.fcw = fcw; v.ph = ph; v.mode = mode;
    v.exp_wave = w; v.exp_wrap = wr; v.exp_rdy = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_cfg(input logic [23:0] fcw, input logic [23:0] ph, input logic [1:0] mode);
    cfg_valid = 1'b1;
    cfg_fcw   = fcw;
    cfg_phase = ph;
    cfg_mode  = mode;
  endtask

  task automatic wait_wrap(input string name, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (wrap_pulse) found = 1'b1;
    end
    chk(name, 32'(found), 32'd1);
  endtask

  initial begin
    logic [15:0] s2_exp[8];
    logic [15:0] s6_exp[8];

    vecs[0]  = mk(1, 1, F22, PA, 2'd2, 16'h8000, 0, 0);
    vecs[1]  = mk(1, 0, 0,   0,  2'd0, 16'h0000, 0, 0);
    vecs[2]  = mk(1, 0, 0,   0,  2'd0, 16'h7FFF, 0, 0);
    vecs[3]  = mk(1, 0, 0,   0,  2'd0, 16'hFFFF, 1, 1);
    vecs[4]  = mk(1, 0, 0,   0,  2'd0, 16'h7FFF, 0, 1);
    vecs[5]  = mk(1, 0, 0,   0,  2'd0, 16'h7FFF, 0, 1);
    vecs[6]  = mk(1, 0, 0,   0,  2'd0, 16'h8000, 0, 1);
    vecs[7]  = mk(1, 0, 0,   0,  2'd0, 16'h8000, 1, 1);
    vecs[8]  = mk(1, 0, 0,   0,  2'd0, 16'h7FFF, 0, 1);
    vecs[9]  = mk(1, 0, 0,   0,  2'd0, 16'h7FFF, 0, 1);
    vecs[10] = mk(1, 0, 0,   0,  2'd0, 16'h8000, 0, 1);
    vecs[11] = mk(1, 1, F21, PA, 2'd1, 16'h8000, 1, 0);
    vecs[12] = mk(1, 0, 0,   0,  2'd0, 16'h7FFF, 0, 0);
    vecs[13] = mk(1, 0, 0,   0,  2'd0, 16'h7FFF, 0, 0);
    vecs[14] = mk(1, 0, 0,   0,  2'd0, 16'h8000, 0, 0);
    vecs[15] = mk(1, 0, 0,   0,  2'd0, 16'h8000, 1, 1);
    vecs[16] = mk(1, 0, 0,   0,  2'd0, 16'h8000, 0, 1);
    vecs[17] = mk(1, 0, 0,   0,  2'd0, 16'hA000, 0, 1);
    vecs[18] = mk(1, 0, 0,   0,  2'd0, 16'hC000, 0, 1);
    vecs[19] = mk(1, 0, 0,   0,  2'd0, 16'hE000, 0, 1);
    vecs[20] = mk(1, 0, 0,   0,  2'd0, 16'h0000, 0, 1);
    vecs[21] = mk(1, 0, 0,   0,  2'd0, 16'h2000, 0, 1);
    vecs[22] = mk(1, 0, 0,   0,  2'd0, 16'h4000, 0, 1);
    vecs[23] = mk(1, 0, 0,   0,  2'd0, 16'h6000, 1, 1);
    vecs[24] = mk(1, 1, F21, PB, 2'd1, 16'h8000, 0, 0);
    vecs[25] = mk(0, 0, 0,   0,  2'd0, 16'hA000, 0, 1);
    vecs[26] = mk(0, 0, 0,   0,  2'd0, 16'hE000, 0, 1);
    vecs[27] = mk(0, 0, 0,   0,  2'd0, 16'hE000, 0, 1);
    vecs[28] = mk(0, 0, 0,   0,  2'd0, 16'hE000, 0, 1);
    vecs[29] = mk(1, 0, 0,   0,  2'd0, 16'hE000, 0, 1);
    vecs[30] = mk(1, 0, 0,   0,  2'd0, 16'h0000, 0, 1);
    vecs[31] = mk(1, 0, 0,   0,  2'd0, 16'h2000, 0, 1);

    s2_exp = '{16'h8000, 16'h0000, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h0000, 16'h7FFF, 16'hFFFF};
    s6_exp = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000};

    // reset and default triangle
    resetn = 1'b0; enable = 1'b1; cfg_valid = 1'b0;
    cfg_fcw = '0; cfg_phase = '0; cfg_mode = '0;
    step(); step();
    chk("rst_wave", 32'(wave_out), 32'h0000);
    chk("rst_wrap", 32'(wrap_pulse), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    resetn = 1'b1;
    step();
    chk("s1_wave0", 32'(wave_out), 32'h8000);
    step();
    chk("s1_wave1", 32'(wave_out), 32'h8081);

    // triangle at fcw 2^22, applied at the first wrap
    drive_cfg(F22, PA, 2'd0);
    step();
    cfg_valid = 1'b0;
    chk("s2_ready_drop", 32'(cfg_ready), 32'd0);
    wait_wrap("s2_wrap_seen", 1100);
    chk("s2_ready_back", 32'(cfg_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("s2_wave[%0d]", i), 32'(wave_out), 32'(s2_exp[i]));
      chk($sformatf("s2_wrap[%0d]", i), 32'(wrap_pulse), ((i % 4) == 3) ? 32'd1 : 32'd0);
    end

    // square, sawtooth with wrap/capture collision, enable-low apply
    for (int i = 0; i < 32; i++) begin
      enable    = vecs[i].en;
      cfg_valid = vecs[i].vld;
      cfg_fcw   = vecs[i].fcw;
      cfg_phase = vecs[i].ph;
      cfg_mode  = vecs[i].mode;
      step();
      chk($sformatf("vec%0d_wave", i), 32'(wave_out), 32'(vecs[i].exp_wave));
      chk($sformatf("vec%0d_wrap", i), 32'(wrap_pulse), 32'(vecs[i].exp_wrap));
      chk($sformatf("vec%0d_ready", i), 32'(cfg_ready), 32'(vecs[i].exp_rdy));
    end
    cfg_valid = 1'b0;
    enable    = 1'b1;

    // second request during PEND is ignored
    wait_wrap("s6_sync_wrap", 16);
    drive_cfg(F21, PA, 2'd2);
    step();
    chk("s6_first_captured", 32'(cfg_ready), 32'd0);
    drive_cfg(F22, 24'h0, 2'd3);
    step();
    cfg_valid = 1'b0;
    chk("s6_still_pend", 32'(cfg_ready), 32'd0);
    wait_wrap("s6_apply_wrap", 16);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("s6_wave[%0d]", i), 32'(wave_out), 32'(s6_exp[i]));
    end
    chk("s6_period_wrap", 32'(wrap_pulse), 32'd1);

    // asynchronous reset in the middle of PEND
    drive_cfg(F22, 24'h0, 2'd3);
    step();
    cfg_valid = 1'b0;
    chk("s6_pend_ready", 32'(cfg_ready), 32'd0);
    chk("s6_pre_rst_wave", 32'(wave_out), 32'h7FFF);
    resetn = 1'b0;
    #1;
    chk("s6_async_wave", 32'(wave_out), 32'h0000);
    chk("s6_async_ready", 32'(cfg_ready), 32'd1);
    chk("s6_async_wrap", 32'(wrap_pulse), 32'd0);
    step();
    chk("s6_hold_wave", 32'(wave_out), 32'h0000);
    resetn = 1'b1;
    step();
    chk("s6_post_wave0", 32'(wave_out), 32'h8000);
    step();
    chk("s6_post_wave1", 32'(wave_out), 32'h8081);
    chk("s6_post_ready", 32'(cfg_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
